// File: rtl/regfile_mp.sv
// Parametrised two-write-port register file with x0 hardwired to zero, optional
// write-to-read bypass and a sequencer that zeroes the array after reset or on request.
module regfile_mp #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [XLEN-1:0]   RD1,
    output logic [XLEN-1:0]   RD2,
    input  logic              WE,
    input  logic [ADDR_W-1:0] A3,
    input  logic [XLEN-1:0]   WD3,
    input  logic              WE4,
    input  logic [ADDR_W-1:0] A4,
    input  logic [XLEN-1:0]   WD4,
    input  logic              clr_req,
    output logic              ready
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    typedef enum logic {StClear, StReady} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ready_q;
    logic [XLEN-1:0]   regs_q [Depth];

    logic we_a;
    logic we_b;

    assign we_a = (state_q == StReady) && WE  && (A3 != '0);
    assign we_b = (state_q == StReady) && WE4 && (A4 != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StClear;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        state_q <= StReady;
                        ready_q <= 1'b1;
                    end
                end
                StReady: begin
                    if (clr_req) begin
                        state_q <= StClear;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; only the sequencer zeroes it. Port B is applied last so it wins.
    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            regs_q[cnt_q] <= '0;
        end else begin
            if (we_a) begin
                regs_q[A3] <= WD3;
            end
            if (we_b) begin
                regs_q[A4] <= WD4;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_mux(input logic [ADDR_W-1:0] addr,
                                                 input logic [XLEN-1:0]   stored);
        if (state_q != StReady || addr == '0) begin
            return '0;
        end
        if (BYPASS != 0 && we_b && A4 == addr) begin
            return WD4;
        end
        if (BYPASS != 0 && we_a && A3 == addr) begin
            return WD3;
        end
        return stored;
    endfunction

    assign RD1   = read_mux(A1, regs_q[A1]);
    assign RD2   = read_mux(A2, regs_q[A2]);
    assign ready = ready_q;

endmodule
